// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: destination-register scoreboard, round-robin arbitration
// between two writeback requesters, and a registered register-file write port.
module regfile_wb_ctrl #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  output logic              alloc_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              req0_valid,
  input  logic [4:0]        req0_rd,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_rd,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [DWIDTH-1:0] rf_wdata
);

  logic [31:0]       busy_q, busy_d;
  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [DWIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic              grant0, grant1;
  logic              alloc_fire;

  // Contention goes to whoever did not win last; no grants while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign alloc_ready = !rst && ((alloc_rd == 5'd0) || !busy_q[alloc_rd]);
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_rd != 5'd0);
  assign rs1_busy    = (rs1 != 5'd0) && busy_q[rs1];
  assign rs2_busy    = (rs2 != 5'd0) && busy_q[rs2];

  always_comb begin
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    // Clear lands on the same edge the register file captures the data.
    if (rf_we_q) begin
      busy_d[rf_addr_q] = 1'b0;
    end
    if (alloc_fire) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (grant0) begin
      last_grant_d = 1'b0;
      rf_we_d      = (req0_rd != 5'd0);
      rf_addr_d    = req0_rd;
      rf_wdata_d   = req0_data;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      rf_we_d      = (req1_rd != 5'd0);
      rf_addr_d    = req1_rd;
      rf_wdata_d   = req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
